// File: rtl/stream_demux_ctrl_if.sv
// Stream bundle for stream_demux_ctrl: one valid/ready input packet stream
// fanned out to WIDTH one-entry output channels with their own handshakes.
interface stream_demux_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8
);
    localparam int SEL_WIDTH = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    logic [SIZE-1:0]      in_data;
    logic [SEL_WIDTH-1:0] in_dest;
    logic                 in_last;
    logic                 in_valid;
    logic                 in_ready;
    logic [SIZE-1:0]      out_data [WIDTH];
    logic [WIDTH-1:0]     out_last;
    logic [WIDTH-1:0]     out_valid;
    logic [WIDTH-1:0]     out_ready;

    modport master (
        output in_data, in_dest, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_valid
    );

    modport slave (
        input  in_data, in_dest, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_valid
    );
endinterface

// File: rtl/stream_demux_ctrl.sv
// Packet-steering front end: locks the destination on a packet's first beat,
// routes beats into per-channel one-entry registers, drops and counts bad packets.
module stream_demux_ctrl #(
    parameter int  WIDTH     = 4,
    parameter int  SIZE      = 8,
    localparam int SEL_WIDTH = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_demux_ctrl_if.slave   bus,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);
    localparam logic [SEL_WIDTH:0] WIDTH_EXT = (SEL_WIDTH + 1)'(WIDTH);
    localparam logic [15:0]        DROP_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DROP  = 2'd2
    } state_e;

    state_e               state_q;
    logic [SEL_WIDTH-1:0] dest_q;
    logic                 busy_q;
    logic [15:0]          drop_cnt_q;
    logic [SIZE-1:0]      data_q [WIDTH];
    logic [WIDTH-1:0]     last_q;
    logic [WIDTH-1:0]     valid_q;

    logic [SEL_WIDTH-1:0] cur_dest_s;
    logic                 hdr_ok_s;
    logic                 cur_free_s;
    logic                 in_ready_s;
    logic                 route_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     free_s;
    logic [WIDTH-1:0]     load_s;

    // With a power-of-two channel count every encodable destination exists.
    if ((1 << SEL_WIDTH) == WIDTH) begin : g_all_dest_ok
        assign hdr_ok_s = 1'b1;
    end else begin : g_range_check
        assign hdr_ok_s = ({1'b0, bus.in_dest} < WIDTH_EXT);
    end

    // Destination lookup, per-channel free test and input handshake decode
    always_comb begin
        free_s     = ~valid_q | bus.out_ready;
        cur_dest_s = (state_q == ST_IDLE) ? bus.in_dest : dest_q;
        cur_free_s = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            cur_free_s = cur_free_s | (free_s[k] & (cur_dest_s == SEL_WIDTH'(k)));
        end
        case (state_q)
            ST_IDLE: begin
                in_ready_s = hdr_ok_s ? cur_free_s : 1'b1;
                route_s    = hdr_ok_s;
            end
            ST_ROUTE: begin
                in_ready_s = cur_free_s;
                route_s    = 1'b1;
            end
            ST_DROP: begin
                in_ready_s = 1'b1;
                route_s    = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
                route_s    = 1'b0;
            end
        endcase
        accept_s = bus.in_valid & in_ready_s;
        load_s   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            load_s[k] = accept_s & route_s & (cur_dest_s == SEL_WIDTH'(k));
        end
    end

    // Packet framing FSM: destination lock, busy flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (hdr_ok_s) begin
                        dest_q  <= bus.in_dest;
                        state_q <= bus.in_last ? ST_IDLE : ST_ROUTE;
                    end else begin
                        if (drop_cnt_q != DROP_MAX) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        state_q <= bus.in_last ? ST_IDLE : ST_DROP;
                    end
                    busy_q <= ~bus.in_last;
                end
                ST_ROUTE, ST_DROP: begin
                    if (bus.in_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel one-entry output registers; load wins over drain so a
    // simultaneous load and drain streams without a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < WIDTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (load_s[k]) begin
                    data_q[k]  <= bus.in_data;
                    last_q[k]  <= bus.in_last;
                    valid_q[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = valid_q;
    assign sel           = dest_q;
    assign busy          = busy_q;
    assign drop_cnt      = drop_cnt_q;
endmodule
